// File: rtl/hdc_pkg.sv
// Shared state encoding, output-mode constants and the saturating adder
// used by every accumulator lane of the HDC bundler.
package hdc_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DRAIN = 2'd2
  } bundle_state_t;

  localparam int OUTPUT_MODE_SUM     = 0;
  localparam int OUTPUT_MODE_BIPOLAR = 1;

  typedef struct packed {
    logic               ovf;
    logic signed [63:0] value;
  } sat_result_t;

  // Operands arrive sign-extended to 64 bits; the 65-bit sum cannot wrap.
  function automatic sat_result_t sat_add(input logic signed [63:0] a,
                                          input logic signed [63:0] b,
                                          input int width);
    logic signed [64:0] sum;
    logic signed [64:0] hi;
    logic signed [64:0] lo;
    sat_result_t        res;
    sum     = 65'(a) + 65'(b);
    hi      = (65'sd1 <<< (width - 1)) - 65'sd1;
    lo      = -hi - 65'sd1;
    res.ovf = 1'b0;
    if (sum > hi) begin
      res.value = 64'(hi);
      res.ovf   = 1'b1;
    end else if (sum < lo) begin
      res.value = 64'(lo);
      res.ovf   = 1'b1;
    end else begin
      res.value = 64'(sum);
    end
    return res;
  endfunction

endpackage

// File: rtl/hdc_bundle_accumulator_if.sv
// Input and output chunk streams of the bundle accumulator (ready/valid).
interface hdc_bundle_accumulator_if #(
  parameter int NUM_PARALLEL_KERNELS = 4,
  parameter int ELEMENT_WIDTH        = 8,
  parameter int ACC_WIDTH            = 16
);
  logic                                      in_valid;
  logic                                      in_ready;
  logic [NUM_PARALLEL_KERNELS*ELEMENT_WIDTH-1:0] in_chunk;
  logic                                      in_last;
  logic                                      out_valid;
  logic                                      out_ready;
  logic [NUM_PARALLEL_KERNELS*ACC_WIDTH-1:0] out_chunk;
  logic                                      out_last;

  modport master (
    output in_valid, in_chunk, in_last, out_ready,
    input  in_ready, out_valid, out_chunk, out_last
  );

  modport slave (
    input  in_valid, in_chunk, in_last, out_ready,
    output in_ready, out_valid, out_chunk, out_last
  );
endinterface

// File: rtl/hdc_sat_lane.sv
// One accumulator element: saturating add (or clear) and the bipolar sign
// of the current accumulator value.
module hdc_sat_lane
  import hdc_pkg::*;
#(
  parameter int ELEMENT_WIDTH = 8,
  parameter int ACC_WIDTH     = 16
) (
  input  logic signed [ACC_WIDTH-1:0]     acc,
  input  logic signed [ELEMENT_WIDTH-1:0] elem,
  input  logic                            clear,
  output logic signed [ACC_WIDTH-1:0]     sum,
  output logic                            ovf,
  output logic signed [ACC_WIDTH-1:0]     bipolar
);
  sat_result_t res;

  always_comb begin
    res     = sat_add(64'(acc), 64'(elem), ACC_WIDTH);
    sum     = clear ? '0 : ACC_WIDTH'(res.value);
    ovf     = res.ovf & ~clear;
    // Zero counts as positive so ties resolve to +1.
    bipolar = acc[ACC_WIDTH-1] ? '1 : ACC_WIDTH'(1);
  end
endmodule

// File: rtl/hdc_bundle_accumulator.sv
// Streaming multi-vector bundler: accumulates chunks of signed elements into
// a saturating per-element array and drains raw sums or bipolar majority.
module hdc_bundle_accumulator
  import hdc_pkg::*;
#(
  parameter int ELEMENT_WIDTH          = 8,
  parameter int ACC_WIDTH              = 16,
  parameter int HYPERVECTOR_DIMENSIONS = 100,
  parameter int NUM_PARALLEL_KERNELS   = 4,
  parameter int MAX_BUNDLE             = 255,
  parameter int OUTPUT_MODE            = 1,
  localparam int VEC_COUNT_WIDTH       = $clog2(MAX_BUNDLE + 1)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  hdc_bundle_accumulator_if.slave    bus,
  output logic                       busy,
  output logic                       overflow,
  output logic [VEC_COUNT_WIDTH-1:0] vec_count,
  output logic                       done
);
  localparam int K          = NUM_PARALLEL_KERNELS;
  localparam int NUM_CHUNKS = (HYPERVECTOR_DIMENSIONS + K - 1) / K;
  localparam int IDX_WIDTH  = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam logic [IDX_WIDTH-1:0] LAST_CHUNK = IDX_WIDTH'(NUM_CHUNKS - 1);
  localparam logic [VEC_COUNT_WIDTH-1:0] LAST_VEC = VEC_COUNT_WIDTH'(MAX_BUNDLE - 1);

  bundle_state_t                            state_reg;
  logic [IDX_WIDTH-1:0]                     chunk_idx_reg;
  logic [IDX_WIDTH-1:0]                     drain_idx_reg;
  logic [VEC_COUNT_WIDTH-1:0]               vec_count_reg;
  logic                                     overflow_reg;
  logic                                     done_reg;
  logic [NUM_CHUNKS-1:0][K-1:0][ACC_WIDTH-1:0] acc_reg;

  logic [IDX_WIDTH-1:0]         row;
  logic [K-1:0][ACC_WIDTH-1:0]  lane_sum;
  logic [K-1:0][ACC_WIDTH-1:0]  lane_bipolar;
  logic [K-1:0]                 lane_ovf;
  logic [K-1:0]                 lane_live;
  logic                         draining;
  logic                         in_fire;
  logic                         out_fire;

  assign draining = (state_reg == S_DRAIN);
  assign row      = draining ? drain_idx_reg : chunk_idx_reg;
  assign in_fire  = bus.in_valid && (state_reg == S_ACCUM);
  assign out_fire = bus.out_ready && draining;

  // The lanes serve the accumulating row in S_ACCUM and clear the drained row.
  generate
    for (genvar gi = 0; gi < K; gi++) begin : g_lane
      localparam bit PAD = ((NUM_CHUNKS - 1) * K + gi) >= HYPERVECTOR_DIMENSIONS;

      assign lane_live[gi] = !(PAD && (row == LAST_CHUNK));

      hdc_sat_lane #(
        .ELEMENT_WIDTH (ELEMENT_WIDTH),
        .ACC_WIDTH     (ACC_WIDTH)
      ) u_lane (
        .acc     (acc_reg[row][gi]),
        .elem    (bus.in_chunk[gi*ELEMENT_WIDTH +: ELEMENT_WIDTH]),
        .clear   (draining),
        .sum     (lane_sum[gi]),
        .ovf     (lane_ovf[gi]),
        .bipolar (lane_bipolar[gi])
      );

      assign bus.out_chunk[gi*ACC_WIDTH +: ACC_WIDTH] =
          !(draining && lane_live[gi])          ? '0 :
          (OUTPUT_MODE == OUTPUT_MODE_BIPOLAR)  ? lane_bipolar[gi] :
                                                  acc_reg[row][gi];
    end
  endgenerate

  assign bus.in_ready  = (state_reg == S_ACCUM);
  assign bus.out_valid = draining;
  assign bus.out_last  = draining && (drain_idx_reg == LAST_CHUNK);
  assign busy          = (state_reg != S_IDLE);
  assign overflow      = overflow_reg;
  assign vec_count     = vec_count_reg;
  assign done          = done_reg;

  // Padding lanes are never written, so they stay zero from reset onward.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_reg <= '0;
    end else if (in_fire || out_fire) begin
      for (int k = 0; k < K; k++) begin
        if (lane_live[k]) begin
          acc_reg[row][k] <= lane_sum[k];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= S_IDLE;
      chunk_idx_reg <= '0;
      drain_idx_reg <= '0;
      vec_count_reg <= '0;
      overflow_reg  <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            state_reg     <= S_ACCUM;
            vec_count_reg <= '0;
            overflow_reg  <= 1'b0;
            chunk_idx_reg <= '0;
          end
        end
        S_ACCUM: begin
          if (bus.in_valid) begin
            if (|(lane_ovf & lane_live)) begin
              overflow_reg <= 1'b1;
            end
            if (chunk_idx_reg == LAST_CHUNK) begin
              chunk_idx_reg <= '0;
              vec_count_reg <= vec_count_reg + VEC_COUNT_WIDTH'(1);
              if (bus.in_last || (vec_count_reg == LAST_VEC)) begin
                state_reg     <= S_DRAIN;
                drain_idx_reg <= '0;
              end
            end else begin
              chunk_idx_reg <= chunk_idx_reg + IDX_WIDTH'(1);
            end
          end
        end
        S_DRAIN: begin
          if (bus.out_ready) begin
            if (drain_idx_reg == LAST_CHUNK) begin
              state_reg     <= S_IDLE;
              drain_idx_reg <= '0;
              done_reg      <= 1'b1;
            end else begin
              drain_idx_reg <= drain_idx_reg + IDX_WIDTH'(1);
            end
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end
endmodule
